// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV64 funct3
// encodings and the access-size decode.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; the unsigned variants share the low two bits.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic for the load/store unit: load extract with sign/zero
// extension, and sub-word store merge into the old memory word.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        offset,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_word
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] bmask;
    logic [DATA_W-1:0] bmask_sh;
    logic [5:0]        bit_off;

    always_comb begin
        bit_off = {offset, 3'b000};
        shifted = word >> bit_off;
        ld_data = '0;
        case (funct3)
            F3_B:    ld_data = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
            F3_H:    ld_data = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            F3_D:    ld_data = shifted;
            F3_BU:   ld_data = {{(DATA_W-8){1'b0}},  shifted[7:0]};
            F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            F3_WU:   ld_data = {{(DATA_W-32){1'b0}}, shifted[31:0]};
            default: ld_data = '0;
        endcase

        // Only the addressed bytes take the low bytes of wdata.
        bmask = '0;
        case (funct3[1:0])
            2'b00:   bmask[7:0]  = '1;
            2'b01:   bmask[15:0] = '1;
            2'b10:   bmask[31:0] = '1;
            default: bmask       = '1;
        endcase
        bmask_sh = bmask << bit_off;
        st_word  = (word & ~bmask_sh) | ((wdata << bit_off) & bmask_sh);
    end

endmodule

// File: rtl/load_store_unit.sv
// Request/response load-store unit in front of datamemory; sub-word stores
// are done as read-modify-write of the whole 64-bit word.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [63:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  dm_memread,
    output logic                  dm_memwrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    input  logic [DATA_W-1:0]     dm_rd
);

    lsu_state_t        state, state_nx;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept, illegal, misal, bad;
    logic [3:0]        sz, szm1;
    logic [DATA_W-1:0] ld_data, st_word;
    logic              unused_addr;

    // Address bits above the memory range wrap and are ignored.
    assign unused_addr = ^req_addr[63:DM_ADDRESS+3];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        sz      = size_bytes(req_funct3);
        szm1    = sz - 4'd1;
        misal   = |(req_addr[2:0] & szm1[2:0]);
        illegal = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
        bad     = misal || illegal;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (bad)                                  state_nx = RESP;
                else if (req_we && req_funct3 == F3_D)    state_nx = WR;
                else                                      state_nx = RD;
            end
            RD:      state_nx = we_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .word    (dm_rd),
        .offset  (off_q),
        .funct3  (f3_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // Strobes are registered from the next state so they align with RD/WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            dm_memread  <= 1'b0;
            dm_memwrite <= 1'b0;
            dm_a        <= '0;
            dm_wd       <= '0;
        end else begin
            state       <= state_nx;
            dm_memread  <= (state_nx == RD);
            dm_memwrite <= (state_nx == WR);
            resp_valid  <= (state_nx == RESP);
            case (state)
                IDLE: if (accept) begin
                    we_q       <= req_we;
                    f3_q       <= req_funct3;
                    off_q      <= req_addr[2:0];
                    wdata_q    <= req_wdata;
                    dm_a       <= req_addr[DM_ADDRESS+2:3];
                    resp_err   <= bad;
                    resp_rdata <= '0;
                    if (req_we && req_funct3 == F3_D) dm_wd <= req_wdata;
                end
                RD: begin
                    if (we_q) dm_wd <= st_word;
                    else      resp_rdata <= ld_data;
                end
                RESP: if (resp_ready) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, multi-cycle corner
// sequences and random traffic checked against a byte-addressed memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        dm_memread, dm_memwrite;
    logic [8:0]  dm_a;
    logic [63:0] dm_wd, dm_rd;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dm_memread  (dm_memread),
        .dm_memwrite (dm_memwrite),
        .dm_a        (dm_a),
        .dm_wd       (dm_wd),
        .dm_rd       (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datamemory stand-in: combinational read, whole-word write on the edge.
    logic [63:0] mem [512];
    logic        bd_we;
    logic [8:0]  bd_a;
    logic [63:0] bd_d;
    assign dm_rd = mem[dm_a];
    always @(posedge clk) begin
        if (dm_memwrite)  mem[dm_a] <= dm_wd;
        else if (bd_we)   mem[bd_a] <= bd_d;
    end

    // Reference model: flat byte array, 4096 bytes.
    logic [7:0] ref_mem [4096];

    int n_chk  = 0;
    int n_pass = 0;
    int overlap = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    function automatic void ref_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                   input logic [63:0] wd, output logic [63:0] rd,
                                   output logic err, output int lat);
        int sz, base;
        logic [63:0] ones;
        sz   = 1 << f3[1:0];
        base = int'(addr[11:0]);
        rd   = '0;
        err  = 1'b0;
        ones = '1;
        if ((we && f3 >= 3'd4) || (!we && f3 == 3'd7) || (base % sz) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        if (we) begin
            for (int k = 0; k < sz; k++) ref_mem[base+k] = wd[8*k +: 8];
            lat = (sz == 8) ? 2 : 3;
        end else begin
            for (int k = 0; k < sz; k++) rd[8*k +: 8] = ref_mem[base+k];
            if (!f3[2] && sz < 8 && rd[8*sz-1]) rd = rd | (ones << (8*sz));
            lat = 2;
        end
    endfunction

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, output logic [63:0] rdata, output logic err,
                         output int lat, output int nrd, output int nwr, output logic [63:0] wword);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; wword = '0;
        while (!resp_valid && lat < 20) begin
            if (dm_memread) nrd++;
            if (dm_memwrite) begin nwr++; wword = dm_wd; end
            if (dm_memread && dm_memwrite) overlap++;
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
        chk("ready_after_handshake", {62'd0, req_ready, resp_valid}, 64'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_err"},   64'(resp_err),   64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata,      64'd0);
        chk({tag, "_memread"},    64'(dm_memread), 64'd0);
        chk({tag, "_memwrite"},   64'(dm_memwrite),64'd0);
        chk({tag, "_dm_a"},       64'(dm_a),       64'd0);
        chk({tag, "_dm_wd"},      dm_wd,           64'd0);
        chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [63:0] exp_wd;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [63:0] w, rd, wword, exp_rd, held;
        logic        err, exp_err;
        int          lat, nrd, nwr, exp_lat, guard;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        bd_we = 1'b0; bd_a = '0; bd_d = '0;

        for (int i = 0; i < 512; i++) begin
            w = {$urandom, $urandom};
            @(negedge clk);
            bd_we = 1'b1; bd_a = 9'(i); bd_d = w;
            for (int k = 0; k < 8; k++) ref_mem[i*8+k] = w[8*k +: 8];
        end
        @(negedge clk);
        bd_we = 1'b0;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        //          we    f3      addr                    wdata                   exp_rd                  err  lat rd wr exp_wd
        vecs[0]  = '{1'b1, 3'b011, 64'h10,                 64'h0123456789ABCDEF,   64'h0,                  1'b0, 2, 0, 1, 64'h0123456789ABCDEF};
        vecs[1]  = '{1'b0, 3'b011, 64'h10,                 64'h0,                  64'h0123456789ABCDEF,   1'b0, 2, 1, 0, 64'h0};
        vecs[2]  = '{1'b1, 3'b000, 64'h13,                 64'hAAAAAAAAAAAAAAFF,   64'h0,                  1'b0, 3, 1, 1, 64'h01234567FFABCDEF};
        vecs[3]  = '{1'b0, 3'b000, 64'h13,                 64'h0,                  64'hFFFFFFFFFFFFFFFF,   1'b0, 2, 1, 0, 64'h0};
        vecs[4]  = '{1'b0, 3'b100, 64'h13,                 64'h0,                  64'h00000000000000FF,   1'b0, 2, 1, 0, 64'h0};
        vecs[5]  = '{1'b0, 3'b101, 64'h14,                 64'h0,                  64'h0000000000004567,   1'b0, 2, 1, 0, 64'h0};
        vecs[6]  = '{1'b0, 3'b010, 64'h12,                 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
        vecs[7]  = '{1'b1, 3'b010, 64'h14,                 64'h11112222DEADBEEF,   64'h0,                  1'b0, 3, 1, 1, 64'hDEADBEEFFFABCDEF};
        vecs[8]  = '{1'b0, 3'b110, 64'h14,                 64'h0,                  64'h00000000DEADBEEF,   1'b0, 2, 1, 0, 64'h0};
        vecs[9]  = '{1'b0, 3'b010, 64'h14,                 64'h0,                  64'hFFFFFFFFDEADBEEF,   1'b0, 2, 1, 0, 64'h0};
        vecs[10] = '{1'b0, 3'b001, 64'h16,                 64'h0,                  64'hFFFFFFFFFFFFDEAD,   1'b0, 2, 1, 0, 64'h0};
        vecs[11] = '{1'b0, 3'b011, 64'hFFFF000000001010,   64'h0,                  64'hDEADBEEFFFABCDEF,   1'b0, 2, 1, 0, 64'h0};
        vecs[12] = '{1'b1, 3'b100, 64'h18,                 64'h1234,               64'h0,                  1'b1, 1, 0, 0, 64'h0};
        vecs[13] = '{1'b0, 3'b111, 64'h18,                 64'h0,                  64'h0,                  1'b1, 1, 0, 0, 64'h0};
        vecs[14] = '{1'b1, 3'b001, 64'h21,                 64'h1234,               64'h0,                  1'b1, 1, 0, 0, 64'h0};
        vecs[15] = '{1'b1, 3'b011, 64'h14,                 64'h55,                 64'h0,                  1'b1, 1, 0, 0, 64'h0};
        vecs[16] = '{1'b1, 3'b001, 64'h12,                 64'h000000000000BEEF,   64'h0,                  1'b0, 3, 1, 1, 64'hDEADBEEFBEEFCDEF};
        vecs[17] = '{1'b0, 3'b000, 64'h17,                 64'h0,                  64'hFFFFFFFFFFFFFFDE,   1'b0, 2, 1, 0, 64'h0};

        for (int i = 0; i < 18; i++) begin
            ref_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, exp_rd, exp_err, exp_lat);
            do_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, err, lat, nrd, nwr, wword);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_memread_cycles", i), 64'(nrd), 64'(vecs[i].exp_nrd));
            chk($sformatf("vec%0d_memwrite_cycles", i), 64'(nwr), 64'(vecs[i].exp_nwr));
            if (vecs[i].exp_nwr != 0) chk($sformatf("vec%0d_dm_wd", i), wword, vecs[i].exp_wd);
        end

        // Response backpressure on a load.
        ref_op(1'b0, 3'b011, 64'h10, 64'h0, exp_rd, exp_err, exp_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        chk("bp_resp_seen", 64'(resp_valid), 64'd1);
        held = resp_rdata;
        chk("bp_rdata", held, exp_rd);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 64'(resp_valid), 64'd1);
            chk("bp_data_held", resp_rdata, held);
            chk("bp_req_ready_low", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_idle", {62'd0, req_ready, resp_valid}, 64'd2);

        // Reset while an SH sits in RD: memory must stay unmodified.
        ref_op(1'b0, 3'b011, 64'h20, 64'h0, exp_rd, exp_err, exp_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 64'h20; req_wdata = 64'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sh_in_rd", 64'(dm_memread), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_rd");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 3'b011, 64'h20, 64'h0, rd, err, lat, nrd, nwr, wword);
        chk("rst_rd_mem_kept", rd, exp_rd);

        // Reset while an SD sits in WR: write strobe drops at once.
        ref_op(1'b0, 3'b011, 64'h28, 64'h0, exp_rd, exp_err, exp_lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h28; req_wdata = 64'hCAFEF00DCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sd_in_wr", 64'(dm_memwrite), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_wr");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 3'b011, 64'h28, 64'h0, rd, err, lat, nrd, nwr, wword);
        chk("rst_wr_mem_kept", rd, exp_rd);

        // Random traffic against the byte model.
        for (int n = 0; n < 300; n++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [63:0] raddr, rwd, amask;
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = {$urandom, $urandom};
            rwd   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                amask = (64'd1 << rf3[1:0]) - 64'd1;
                raddr = raddr & ~amask;
            end
            ref_op(rwe, rf3, raddr, rwd, exp_rd, exp_err, exp_lat);
            do_op(rwe, rf3, raddr, rwd, rd, err, lat, nrd, nwr, wword);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), 64'(err), 64'(exp_err));
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(exp_lat));
        end

        chk("no_read_write_overlap", 64'(overlap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
